// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit serializer.
//   tx_state_t       : serializer FSM states
//   UART_DATA_BITS   : data bits per frame
//   UART_IDLE_LEVEL  : line level while idle and during the stop bit
//   UART_START_LEVEL : line level during the start bit
// Optional feature macro used by the design files: UART_TX_PARITY_EN
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous byte FIFO feeding the serializer. Read data is the entry at
// the read pointer (combinational read), there is no empty-to-output bypass.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din (ignored when full)
//   pop      : advance read pointer (ignored when empty)
//   din      : write data
//   dout     : head-of-queue data
//   full     : DEPTH entries stored
//   empty    : no entries stored
//   count    : registered occupancy, 0..DEPTH
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Accepts bytes over a valid/ready port, buffers them in uart_tx_fifo and
// shifts each out LSB first as an 8N1 frame (8E1 with UART_TX_PARITY_EN).
// Ports:
//   CLK      : clock
//   RST      : asynchronous active-high reset
//   wr_valid : byte offered
//   wr_data  : byte offered
//   wr_ready : FIFO not full (from registered occupancy)
//   tx       : registered serial line, idle high
//   busy     : FIFO non-empty or frame in progress
// Parameters: CLKS_PER_BIT (>= 2), FIFO_DEPTH (power of two, >= 2)
// Macro: UART_TX_PARITY_EN adds an even-parity bit between bit 7 and stop.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | data bits 0..7, LSB first
// PARITY | even parity of the byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); chains straight into START if bytes are queued
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      wr_valid,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  output logic                      wr_ready,
  output logic                      tx,
  output logic                      busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_n;
  logic [BW-1:0]             baud_q, baud_n;
  logic [IW-1:0]             bit_idx_q, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shift_q, shift_n;
  logic                      tx_n;
  logic                      baud_last;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_n;
`endif

  assign wr_ready  = !fifo_full;
  assign fifo_push = wr_valid && wr_ready;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);
  assign baud_last = (baud_q == BAUD_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx        <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      baud_q    <= baud_n;
      bit_idx_q <= bit_idx_n;
      shift_q   <= shift_n;
      tx        <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_n;
`endif
    end
  end

  // tx_n is the level of the bit that state_n/shift_n describe, so the
  // registered line changes on the same edge as the state.
  always_comb begin
    state_n   = state_q;
    baud_n    = baud_q;
    bit_idx_n = bit_idx_q;
    shift_n   = shift_q;
    tx_n      = tx;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n     = par_q;
`endif

    case (state_q)
      IDLE: begin
        tx_n = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_dout;
`ifdef UART_TX_PARITY_EN
          par_n    = ^fifo_dout;
`endif
          baud_n   = '0;
          state_n  = START;
          tx_n     = UART_START_LEVEL;
        end
      end

      START: begin
        if (baud_last) begin
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = DATA;
          tx_n      = shift_q[0];
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_idx_n = bit_idx_q + 1'b1;
            shift_n   = shift_q >> 1;
            tx_n      = shift_q[1];
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = STOP;
          tx_n    = UART_IDLE_LEVEL;
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (!fifo_empty) begin
            // Back-to-back: next start bit follows the stop bit directly.
            fifo_pop = 1'b1;
            shift_n  = fifo_dout;
`ifdef UART_TX_PARITY_EN
            par_n    = ^fifo_dout;
`endif
            state_n  = START;
            tx_n     = UART_START_LEVEL;
          end else begin
            state_n = IDLE;
            tx_n    = UART_IDLE_LEVEL;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = UART_IDLE_LEVEL;
      end
    endcase
  end

endmodule
